// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS control path.
// Holds the opcode and func field values, the 4-bit ALU control codes, the
// ALU B-operand and PC-source mux encodings, and the FSM state encoding that
// is also exported on the debug state port. This package has no ports.
package mips_pkg;

  // Opcode field values, instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  // Func field values for R-type, instruction[5:0]
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // FSM states; values are visible on the debug port
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_IDLE   = 4'd15
  } state_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle MIPS sequencer.
// master: the control unit (reads run/opcode/func/zero/mem_ready, drives
//         enables, mux selects, aluop, debug state and the illegal flag).
// slave:  the datapath/memory side, with directions mirrored.
interface multicycle_control_if;

  logic       run;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       regdst;
  logic       regwrite;
  logic       mem2reg;
  logic       extop;
  logic       alusrc_a;
  logic [1:0] alusrc_b;
  logic [1:0] pc_src;
  logic [3:0] aluop;
  logic [3:0] state;
  logic       illegal;

  modport master (
    input  run, opcode, func, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, regdst, regwrite,
           mem2reg, extop, alusrc_a, alusrc_b, pc_src, aluop, state, illegal
  );

  modport slave (
    output run, opcode, func, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, regdst, regwrite,
           mem2reg, extop, alusrc_a, alusrc_b, pc_src, aluop, state, illegal
  );

endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU control resolver.
// Ports: opcode, func (instruction fields), state (current FSM state) ->
//        aluop (4-bit ALU control code), func_illegal (unknown R-type func,
//        only meaningful while in RTEXEC).
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  state_e     state,
  output logic [3:0] aluop,
  output logic       func_illegal
);

  // Select the ALU operation for the current state; ADD everywhere else.
  always_comb begin
    aluop        = ALU_ADD;
    func_illegal = 1'b0;
    case (state)
      S_RTEXEC: begin
        case (func)
          FN_ADD:  aluop = ALU_ADD;
          FN_SUB:  aluop = ALU_SUB;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_SLT:  aluop = ALU_SLT;
          default: begin
            aluop        = ALU_ADD;
            func_illegal = 1'b1;
          end
        endcase
      end
      S_IEXEC: begin
        if (opcode == OP_ORI) begin
          aluop = ALU_OR;
        end else begin
          aluop = ALU_ADD;
        end
      end
      S_BRANCH: aluop = ALU_SUB;
      default:  aluop = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control sequencer for a multi-cycle MIPS datapath with a shared
// memory and a single ALU.
// Ports: clk, rst_n (async active-low), bus (multicycle_control_if.master:
//        run/opcode/func/zero/mem_ready in; datapath enables, mux selects,
//        aluop, debug state and sticky illegal flag out).
// MEM_WAIT_EN = 0 treats mem_ready as always high.
module multicycle_control
  import mips_pkg::*;
#(
  parameter logic MEM_WAIT_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_if.master  bus
);

  state_e     state_r;
  state_e     state_next_s;
  state_e     fetch_target_s;
  logic       illegal_r;
  logic       illegal_set_s;
  logic       started_r;
  logic       ready_s;
  logic       fetch_go_s;
  logic [3:0] aluop_s;
  logic       func_illegal_s;

  alu_decoder u_alu_decoder (
    .opcode       (bus.opcode),
    .func         (bus.func),
    .state        (state_r),
    .aluop        (aluop_s),
    .func_illegal (func_illegal_s)
  );

  // Effective memory handshake and the destination of "go to FETCH".
  // started_r keeps the reset-time FETCH quiet for one cycle so the reset
  // output values hold until the first clock after rst_n releases.
  always_comb begin
    if (MEM_WAIT_EN) begin
      ready_s = bus.mem_ready;
    end else begin
      ready_s = 1'b1;
    end
    fetch_go_s = started_r & bus.run;
    if (bus.run) begin
      fetch_target_s = S_FETCH;
    end else begin
      fetch_target_s = S_IDLE;
    end
  end

  // Next-state and Moore output decode; every output defaulted first.
  always_comb begin
    state_next_s  = state_r;
    illegal_set_s = 1'b0;
    bus.pc_en     = 1'b0;
    bus.iord      = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.ir_write  = 1'b0;
    bus.regdst    = 1'b0;
    bus.regwrite  = 1'b0;
    bus.mem2reg   = 1'b0;
    bus.extop     = 1'b1;
    bus.alusrc_a  = 1'b0;
    bus.alusrc_b  = SRCB_RT;
    bus.pc_src    = PCSRC_ALU;
    bus.aluop     = aluop_s;
    case (state_r)
      S_IDLE: begin
        // an illegal opcode parks the machine here until reset
        if (bus.run && !illegal_r) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (!fetch_go_s) begin
          if (bus.run) begin
            state_next_s = S_FETCH;
          end else begin
            state_next_s = S_IDLE;
          end
        end else begin
          bus.mem_read = 1'b1;
          bus.alusrc_b = SRCB_FOUR;
          if (ready_s) begin
            bus.ir_write = 1'b1;
            bus.pc_en    = 1'b1;
            state_next_s = S_DECODE;
          end else begin
            state_next_s = S_FETCH;
          end
        end
      end
      S_DECODE: begin
        // precompute branch target PC + (imm << 2)
        bus.alusrc_b = SRCB_IMM_SH2;
        case (bus.opcode)
          OP_LW, OP_SW:     state_next_s = S_MEMADR;
          OP_RTYPE:         state_next_s = S_RTEXEC;
          OP_BEQ:           state_next_s = S_BRANCH;
          OP_J:             state_next_s = S_JUMP;
          OP_ADDI, OP_ORI:  state_next_s = S_IEXEC;
          default: begin
            illegal_set_s = 1'b1;
            state_next_s  = S_IDLE;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alusrc_a = 1'b1;
        bus.alusrc_b = SRCB_IMM;
        if (bus.opcode == OP_SW) begin
          state_next_s = S_MEMWR;
        end else begin
          state_next_s = S_MEMRD;
        end
      end
      S_MEMRD: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
        if (ready_s) begin
          state_next_s = S_MEMWB;
        end else begin
          state_next_s = S_MEMRD;
        end
      end
      S_MEMWB: begin
        bus.regwrite = 1'b1;
        state_next_s = fetch_target_s;
      end
      S_MEMWR: begin
        // strobe held through the wait; memory commits on the ready cycle
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
        if (ready_s) begin
          state_next_s = fetch_target_s;
        end else begin
          state_next_s = S_MEMWR;
        end
      end
      S_RTEXEC: begin
        bus.alusrc_a  = 1'b1;
        illegal_set_s = func_illegal_s;
        state_next_s  = S_ALUWB;
      end
      S_ALUWB: begin
        bus.regdst   = 1'b1;
        bus.mem2reg  = 1'b1;
        bus.regwrite = 1'b1;
        state_next_s = fetch_target_s;
      end
      S_IEXEC: begin
        bus.alusrc_a = 1'b1;
        bus.alusrc_b = SRCB_IMM;
        if (bus.opcode == OP_ORI) begin
          bus.extop = 1'b0;
        end else begin
          bus.extop = 1'b1;
        end
        state_next_s = S_IWB;
      end
      S_IWB: begin
        bus.mem2reg  = 1'b1;
        bus.regwrite = 1'b1;
        state_next_s = fetch_target_s;
      end
      S_BRANCH: begin
        // ALU compares rs - rt; target already sits in the ALU out register
        bus.alusrc_a = 1'b1;
        bus.pc_src   = PCSRC_ALUOUT;
        bus.pc_en    = bus.zero;
        state_next_s = fetch_target_s;
      end
      S_JUMP: begin
        bus.pc_src   = PCSRC_JUMP;
        bus.pc_en    = 1'b1;
        state_next_s = fetch_target_s;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State register, sticky illegal flag and post-reset start flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_FETCH;
      illegal_r <= 1'b0;
      started_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      illegal_r <= illegal_r | illegal_set_s;
      started_r <= 1'b1;
    end
  end

  assign bus.state   = state_r;
  assign bus.illegal = illegal_r;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control sequencer that converts the single-cycle MIPS datapath into a multi-cycle machine sharing one memory (instruction and data) and one ALU.
- Moore FSM steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Issues all datapath enables and mux selects, and resolves the 4-bit ALU control code.
- Waits on a memory-ready handshake and halts on an illegal opcode.

Parameters:
- MEM_WAIT_EN, 1, 1 = memory states hold until mem_ready; 0 = mem_ready ignored (treated as 1).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 0 freezes the FSM at the next FETCH entry
- opcode  in  6  instruction[31:26] from the instruction register
- func  in  6  instruction[5:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_en  out  1  PC register load enable (includes branch-taken)
- iord  out  1  memory address select: 0 = PC, 1 = ALU out register
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- regdst  out  1  write address: 0 = rt, 1 = rd
- regwrite  out  1  register file write enable
- mem2reg  out  1  write data: 0 = memory data register, 1 = ALU out
- extop  out  1  1 = sign extend, 0 = zero extend
- alusrc_a  out  1  0 = PC, 1 = rs data
- alusrc_b  out  2  0 = rt data, 1 = constant 4, 2 = extended immediate, 3 = extended immediate << 2
- pc_src  out  2  0 = ALU result, 1 = ALU out register, 2 = jump target
- aluop  out  4  ALU control code
- state  out  4  current state encoding, for debug
- illegal  out  1  sticky; set on an unknown opcode

Behaviour:
- Reset (async, rst_n = 0):
  - state = FETCH; illegal = 0; all enables = 0.
  - Muxes: iord = 0, alusrc_a = 0, alusrc_b = 0, pc_src = 0.
  - Control: extop = 1, aluop = ADD.
  - Reset mid-access aborts the access immediately; no write completes after reset assertion.
- Outputs decode from state only (Moore), except pc_en in BRANCH = zero.
- ALU codes:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
  - R-type maps func: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT; other func values give ADD and set illegal.
- Opcodes: RTYPE 0x00, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02, ADDI 0x08, ORI 0x0D.
- States and transitions:
  - IDLE: all enables 0. Goes to FETCH when run = 1.
  - FETCH:
    - Outputs: mem_read = 1, iord = 0, alusrc_a = 0, alusrc_b = 1, aluop = ADD, pc_src = 0.
    - When mem_ready: ir_write = 1, pc_en = 1, next DECODE. Otherwise hold with ir_write and pc_en = 0.
    - Entering FETCH with run = 0 goes to IDLE instead; no strobes are issued that cycle.
  - DECODE:
    - Outputs: alusrc_a = 0, alusrc_b = 3, aluop = ADD (branch target precomputed).
    - Next state by opcode: LW/SW → MEMADR; RTYPE → RTEXEC; BEQ → BRANCH; J → JUMP; ADDI/ORI → IEXEC.
    - Any other opcode: illegal = 1, next IDLE. The FSM stays in IDLE until reset, regardless of run.
  - MEMADR: alusrc_a = 1, alusrc_b = 2, extop = 1, aluop = ADD. Next MEMRD for LW, MEMWR for SW.
  - MEMRD: iord = 1, mem_read = 1; hold until mem_ready, then MEMWB.
  - MEMWB: regdst = 0, mem2reg = 0, regwrite = 1. Next FETCH.
  - MEMWR: iord = 1, mem_write = 1; hold until mem_ready, then FETCH.
    - mem_write stays asserted throughout the wait; the memory writes exactly once on the ready cycle.
  - RTEXEC: alusrc_a = 1, alusrc_b = 0, aluop from func. Next ALUWB.
  - ALUWB: regdst = 1, mem2reg = 1, regwrite = 1. Next FETCH.
  - IEXEC: alusrc_a = 1, alusrc_b = 2. ADDI: extop = 1, aluop ADD. ORI: extop = 0, aluop OR. Next IWB.
  - IWB: regdst = 0, mem2reg = 1, regwrite = 1. Next FETCH.
  - BRANCH: alusrc_a = 1, alusrc_b = 0, aluop = SUB, pc_src = 1, pc_en = zero. Next FETCH.
  - JUMP: pc_src = 2, pc_en = 1. Next FETCH.
- Cycle counts with mem_ready held high:
  - LW 5; SW 4; R-type 4; ADDI/ORI 4; BEQ 3; J 3.
  - Each wait cycle adds 1.
- Simultaneous events:
  - run falling mid-instruction completes that instruction, then stops at IDLE.
  - mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- State encoding (debug port):
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, ALUWB 7.
  - BRANCH 8, JUMP 9, IEXEC 10, IWB 11, IDLE 15.
- Every output is driven in every state; no latches.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants, func constants, ALU control codes;
  - alusrc_b encodings, pc_src encodings, state encodings.
- Sub-module alu_decoder (combinational): opcode, func, state → aluop, func_illegal.
- The FSM and output decode stay in multicycle_control.

Test Plan:
- Reset: drive rst_n = 0 mid-MEMWR with mem_write = 1 → mem_write drops to 0 within the same cycle, state = 0, illegal = 0.
- LW 0x8C220004, run = 1, mem_ready = 1 → states 0,1,2,3,4,0; regwrite = 1 only in state 4 with regdst = 0, mem2reg = 0; 5 cycles total.
- SW 0xAC220008 with mem_ready low for 3 cycles in MEMWR → mem_write high for 4 cycles, never regwrite, then FETCH.
- R-type sub (func 0x22) then slt (func 0x2A) → aluop 0110 then 0111 in RTEXEC; ALUWB has regdst = 1.
- BEQ with zero = 1, then zero = 0 → pc_en = 1 then 0 in state 8, pc_src = 1 both times; J 0x08000010 → state 9 with pc_src = 2, pc_en = 1.
- Opcode 0x3F → illegal = 1 after DECODE, state = 15 held for 20 cycles with run = 1; ORI → extop = 0, aluop = 0001 in IEXEC.
